ann_layer: RTL

Parametrised fully-connected layer engine for the fixed-point neural-network datapath. It computes N_OUT neurons one after another on a single shared multiply-accumulate unit. Each neuron consumes N_IN streamed (value, weight) beats plus a bias. The activation function is selectable per run, and each result is emitted on a valid/ready output stream. It supersedes the single-neuron datapath/controller pair: N_IN, N_OUT, width and fraction bits are all parameters, with backpressure on both streams.

---
 rtl/ann_pkg.sv | 46 ++++
 rtl/ann_mac_act.sv | 42 ++++
 rtl/ann_layer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// ann_pkg: shared types and helpers for the fully-connected layer engine.
//   state_t   - controller states (IDLE, ACC, FIN, OUT)
//   ACT_*     - act_mode encodings (3 is reserved and behaves as linear)
//   acc_w()   - accumulator width that cannot overflow over n_in products
//   idx_w()   - counter/index width, never below 1 bit
//   sat_s()   - clamp a wide signed value into a dw-bit signed range
package ann_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      FIN  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [1:0] ACT_LIN   = 2'd0;
   localparam logic [1:0] ACT_RELU  = 2'd1;
   localparam logic [1:0] ACT_LEAKY = 2'd2;

   // Working width for the post-accumulate arithmetic; ACC_W must fit in it.
   localparam int SAT_W = 64;

   function automatic int acc_w(input int dw, input int n_in);
      return 2 * dw + $clog2(n_in) + 1;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] x,
                                                     input int dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/ann_mac_act.sv
// ann_mac_act: combinational neuron finisher.
//   acc  - signed accumulated sum of value*weight products (ACC_W bits)
//   bias - signed bias in the same Q format as the operands
//   mode - activation select (linear / ReLU / leaky ReLU, 3 = linear)
//   res  - (acc + bias<<<FW) >>> FW, activated, then saturated to DW bits
module ann_mac_act
   import ann_pkg::*;
#(
   parameter int DW    = 8,
   parameter int FW    = 4,
   parameter int ACC_W = 2 * DW + 1
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [DW-1:0]    bias,
   input  logic        [1:0]       mode,
   output logic signed [DW-1:0]    res
);

   logic signed [SAT_W-1:0] acc_x;
   logic signed [SAT_W-1:0] bias_x;
   logic signed [SAT_W-1:0] sum;
   logic signed [SAT_W-1:0] r;
   logic signed [SAT_W-1:0] act;

   always_comb begin
      acc_x  = {{(SAT_W - ACC_W){acc[ACC_W-1]}}, acc};
      bias_x = {{(SAT_W - DW){bias[DW-1]}}, bias};
      sum    = acc_x + (bias_x <<< FW);
      // Arithmetic shift floors toward negative infinity.
      r      = sum >>> FW;
      case (mode)
         ACT_LIN:   act = r;
         ACT_RELU:  act = (r < 64'sd0) ? 64'sd0 : r;
         ACT_LEAKY: act = (r < 64'sd0) ? (r >>> 3) : r;
         default:   act = r;
      endcase
   end

   // Saturation comes after activation so leaky scaling sees the full value.
   assign res = DW'(sat_s(act, DW));

endmodule

// File: rtl/ann_layer.sv
// ann_layer: fully-connected layer on one shared MAC.
//   clk, rst (async, active-low)
//   start, act_mode        - run request and activation, latched when idle
//   in_valid/in_ready      - (value, weight, bias) beat stream; bias used on beat 0
//   out_valid/out_ready    - result stream: out_data (activated, saturated), out_idx
//   busy                   - any state other than IDLE
//   done                   - one-cycle pulse after the last result is consumed
module ann_layer
   import ann_pkg::*;
#(
   parameter int DW    = 8,
   parameter int FW    = 4,
   parameter int N_IN  = 10,
   parameter int N_OUT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                act_mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DW-1:0]      value,
   input  logic signed [DW-1:0]      weight,
   input  logic signed [DW-1:0]      bias,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DW-1:0]      out_data,
   output logic [idx_w(N_OUT)-1:0]   out_idx,
   output logic                      busy,
   output logic                      done
);

   localparam int ACC_W = acc_w(DW, N_IN);
   localparam int IW    = idx_w(N_OUT);
   localparam int CW    = idx_w(N_IN);

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic        [CW-1:0]     in_cnt;
   logic        [IW-1:0]     out_cnt;
   logic signed [DW-1:0]     bias_q;
   logic        [1:0]        mode_q;

   logic signed [2*DW-1:0]   prod_p0;
   logic signed [ACC_W-1:0]  prod_x_p0;
   logic signed [DW-1:0]     res_p1;

   // Stage 0: product of the beat being accepted, sign-extended to ACC_W.
   assign prod_p0   = value * weight;
   assign prod_x_p0 = {{(ACC_W - 2 * DW){prod_p0[2*DW-1]}}, prod_p0};

   // Stage 1: bias, shift, activation and saturation of the finished sum.
   ann_mac_act #(
      .DW    (DW),
      .FW    (FW),
      .ACC_W (ACC_W)
   ) u_mac_act (
      .acc  (acc),
      .bias (bias_q),
      .mode (mode_q),
      .res  (res_p1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         bias_q    <= '0;
         mode_q    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACC;
                  acc      <= '0;
                  in_cnt   <= '0;
                  out_cnt  <= '0;
                  mode_q   <= act_mode;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACC: begin
               // in_ready is high throughout ACC, so in_valid alone is the handshake.
               if (in_valid) begin
                  acc <= acc + prod_x_p0;
                  if (in_cnt == '0) begin
                     bias_q <= bias;
                  end
                  if (in_cnt == CW'(N_IN - 1)) begin
                     state    <= FIN;
                     in_ready <= 1'b0;
                     in_cnt   <= '0;
                  end else begin
                     in_cnt <= in_cnt + 1'b1;
                  end
               end
            end
            FIN: begin
               out_data  <= res_p1;
               out_idx   <= out_cnt;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_cnt == IW'(N_OUT - 1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     out_cnt  <= out_cnt + 1'b1;
                     acc      <= '0;
                     in_cnt   <= '0;
                     in_ready <= 1'b1;
                     state    <= ACC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
